// File: rtl/mem_xfer_ctrl_if.sv
// Bus bundle between the transfer sequencer and its memories/adder.
interface mem_xfer_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  // command side
  logic              Start;
  logic [ADDR_W-1:0] SrcBase;
  logic [ADDR_W-1:0] DstBase;
  logic [ADDR_W-1:0] Length;
  // source memory read port
  logic [ADDR_W-1:0] M1Addr;
  logic              M1Rd;
  logic [DATA_W-1:0] M1DOut;
  // adder operands and result
  logic [DATA_W-1:0] DOut1;
  logic [DATA_W-1:0] DOut2;
  logic [DATA_W-1:0] ADDOut;
  // destination memory write port
  logic [ADDR_W-1:0] M2Addr;
  logic              M2WE;
  logic [DATA_W-1:0] M2DIn;
  // status
  logic              Busy;
  logic              Done;
  logic              Ovf;

  // environment side: issues commands, models memories and adder
  modport master (
    output Start, SrcBase, DstBase, Length, M1DOut, ADDOut,
    input  M1Addr, M1Rd, DOut1, DOut2, M2Addr, M2WE, M2DIn, Busy, Done, Ovf
  );

  // sequencer side
  modport slave (
    input  Start, SrcBase, DstBase, Length, M1DOut, ADDOut,
    output M1Addr, M1Rd, DOut1, DOut2, M2Addr, M2WE, M2DIn, Busy, Done, Ovf
  );
endinterface

// File: rtl/mem_xfer_ctrl.sv
// Memory-to-memory transfer sequencer: reads operand pairs from Memory 1,
// feeds them to the adder and writes each sum to Memory 2.
module mem_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  mem_xfer_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dout1;
  logic [DATA_W-1:0] r_dout2;
  logic              r_ovf;

  logic              w_ovf;
  logic              w_rd;
  logic              w_wr;

  // Signed overflow: operands agree in sign, sum disagrees
  assign w_ovf = (r_dout1[DATA_W-1] == r_dout2[DATA_W-1]) &&
                 (bus.ADDOut[DATA_W-1] != r_dout1[DATA_W-1]);

  // Sequencer: pointers, operand registers and sticky overflow
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_dout1 <= '0;
      r_dout2 <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_src   <= bus.SrcBase;
            r_dst   <= bus.DstBase;
            r_rem   <= bus.Length;
            r_ovf   <= 1'b0;
            r_state <= (bus.Length == '0) ? S_DONE : S_RD1;
          end
        end
        S_RD1: begin
          r_src   <= r_src + ADDR_W'(1);
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_dout1 <= bus.M1DOut;
          r_src   <= r_src + ADDR_W'(1);
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_dout2 <= bus.M1DOut;
          r_state <= S_WR;
        end
        S_WR: begin
          if (w_ovf) r_ovf <= 1'b1;
          r_dst   <= r_dst + ADDR_W'(1);
          r_rem   <= r_rem - ADDR_W'(1);
          r_state <= (r_rem == ADDR_W'(1)) ? S_DONE : S_RD1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes decoded from the state register only
  assign w_rd = (r_state == S_RD1) || (r_state == S_RD2);
  assign w_wr = (r_state == S_WR);

  assign bus.M1Rd   = w_rd;
  assign bus.M1Addr = w_rd ? r_src : '0;
  assign bus.M2WE   = w_wr;
  assign bus.M2Addr = w_wr ? r_dst : '0;
  assign bus.M2DIn  = w_wr ? bus.ADDOut : '0;
  assign bus.DOut1  = r_dout1;
  assign bus.DOut2  = r_dout2;
  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.Done   = (r_state == S_DONE);
  assign bus.Ovf    = r_ovf;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: a per-cycle expectation table is
// filled from each accepted command and compared on every falling edge.
module tb_mem_xfer_ctrl;

  localparam int MAXC = 1024;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clock = ~Clock;

  mem_xfer_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  mem_xfer_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  // environment: memories and adder
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16] = '{default: 8'h00};
  logic [7:0] m1q = 8'h00;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         last_done = -1;
  int         cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) if (bus.M1Rd) m1q <= mem1[bus.M1Addr];
  assign bus.M1DOut = m1q;
  assign bus.ADDOut = bus.DOut1 + bus.DOut2;

  always @(posedge Clock) begin
    if (bus.M2WE) begin
      mem2[bus.M2Addr] <= bus.M2DIn;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge Clock) begin
    if (bus.Done) begin
      done_cnt  <= done_cnt + 1;
      last_done <= cyc;
    end
  end

  // expectation table indexed by absolute cycle
  bit         exp_busy [MAXC];
  bit         exp_done [MAXC];
  bit         exp_rd   [MAXC];
  bit         exp_we   [MAXC];
  bit         exp_ovf  [MAXC];
  logic [3:0] exp_m1a  [MAXC];
  logic [3:0] exp_m2a  [MAXC];
  logic [7:0] exp_wd   [MAXC];
  logic [7:0] exp_d1   [MAXC];
  logic [7:0] exp_d2   [MAXC];

  int n_tests = 0;
  int n_fail  = 0;
  int s_cmd   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Everything from cycle c onward returns to the reset picture
  function automatic void model_reset(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_busy[k] = 0; exp_done[k] = 0; exp_rd[k] = 0; exp_we[k] = 0;
      exp_ovf[k] = 0; exp_m1a[k] = '0; exp_m2a[k] = '0; exp_wd[k] = '0;
      exp_d1[k] = '0; exp_d2[k] = '0;
    end
  endfunction

  // Command accepted at the edge ending cycle s: pair i occupies cycles
  // s+4i+1..s+4i+4, Done lands in s+4*len+1.
  function automatic void plan(input int s, input logic [3:0] src,
                               input logic [3:0] dst, input logic [3:0] len);
    int n;
    n = int'(len);
    for (int k = s + 1; k < MAXC; k++) exp_ovf[k] = 0;
    for (int k = s + 1; k <= s + 4 * n + 1; k++) exp_busy[k] = 1;
    exp_done[s + 4 * n + 1] = 1;
    for (int i = 0; i < n; i++) begin
      logic [3:0] ra, rb, wa;
      logic [7:0] a, b;
      int         sum;
      int         b0;
      b0 = s + 4 * i;
      ra = 4'(int'(src) + 2 * i);
      rb = 4'(int'(src) + 2 * i + 1);
      wa = 4'(int'(dst) + i);
      a  = mem1[ra];
      b  = mem1[rb];
      sum = int'($signed(a)) + int'($signed(b));
      exp_rd[b0 + 1] = 1; exp_m1a[b0 + 1] = ra;
      exp_rd[b0 + 2] = 1; exp_m1a[b0 + 2] = rb;
      for (int k = b0 + 3; k < MAXC; k++) exp_d1[k] = a;
      for (int k = b0 + 4; k < MAXC; k++) exp_d2[k] = b;
      exp_we[b0 + 4] = 1; exp_m2a[b0 + 4] = wa;
      exp_wd[b0 + 4] = 8'(int'(a) + int'(b));
      if (sum > 127 || sum < -128)
        for (int k = b0 + 5; k < MAXC; k++) exp_ovf[k] = 1;
    end
  endfunction

  // per-cycle comparison against the table
  always @(negedge Clock) begin
    if (ResetN && cyc < MAXC) begin
      chk("busy",  32'(bus.Busy),  32'(exp_busy[cyc]));
      chk("done",  32'(bus.Done),  32'(exp_done[cyc]));
      chk("m1rd",  32'(bus.M1Rd),  32'(exp_rd[cyc]));
      chk("m2we",  32'(bus.M2WE),  32'(exp_we[cyc]));
      chk("ovf",   32'(bus.Ovf),   32'(exp_ovf[cyc]));
      chk("dout1", 32'(bus.DOut1), 32'(exp_d1[cyc]));
      chk("dout2", 32'(bus.DOut2), 32'(exp_d2[cyc]));
      if (exp_rd[cyc]) chk("m1addr", 32'(bus.M1Addr), 32'(exp_m1a[cyc]));
      if (exp_we[cyc]) begin
        chk("m2addr", 32'(bus.M2Addr), 32'(exp_m2a[cyc]));
        chk("m2din",  32'(bus.M2DIn),  32'(exp_wd[cyc]));
      end
    end
  end

  task automatic start_cmd(input logic [3:0] src, input logic [3:0] dst, input logic [3:0] len);
    @(negedge Clock);
    bus.SrcBase = src; bus.DstBase = dst; bus.Length = len; bus.Start = 1'b1;
    s_cmd = cyc;
    plan(s_cmd, src, dst, len);
    @(posedge Clock); #1;
    bus.Start = 1'b0;
  endtask

  task automatic finish_cmd(input int len);
    repeat (4 * len + 1) @(posedge Clock);
    #1;
  endtask

  initial begin
    int w0, d0, s;
    model_reset(0);
    bus.Start = 1'b0; bus.SrcBase = '0; bus.DstBase = '0; bus.Length = '0;
    for (int i = 0; i < 16; i++) mem1[i] = 8'h00;

    // power-on reset state
    @(posedge Clock); #1;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_ovf",  32'(bus.Ovf),  32'd0);
    chk("rst_m1rd", 32'(bus.M1Rd), 32'd0);
    chk("rst_m2we", 32'(bus.M2WE), 32'd0);
    chk("rst_dout1", 32'(bus.DOut1), 32'd0);
    @(posedge Clock); #3 ResetN = 1'b1;
    @(posedge Clock); #1;

    // basic two-pair transfer
    mem1[0] = 8'h00; mem1[1] = 8'h7F; mem1[2] = 8'h22; mem1[3] = 8'h49;
    start_cmd(4'd0, 4'd5, 4'd2);
    finish_cmd(2);
    chk("t2_m2_5", 32'(mem2[5]), 32'h7F);
    chk("t2_m2_6", 32'(mem2[6]), 32'h6B);
    chk("t2_done_cycle", 32'(last_done - s_cmd), 32'd9);
    chk("t2_ovf", 32'(bus.Ovf), 32'd0);
    chk("t2_writes", 32'(wr_cnt), 32'd2);

    // negative operands, overflow on second pair, sticky after Done
    mem1[2] = 8'hE0; mem1[3] = 8'hC7; mem1[4] = 8'h80; mem1[5] = 8'hFF;
    start_cmd(4'd2, 4'd9, 4'd2);
    finish_cmd(2);
    chk("t3_m2_9",  32'(mem2[9]),  32'hA7);
    chk("t3_m2_10", 32'(mem2[10]), 32'h7F);
    repeat (3) @(posedge Clock); #1;
    chk("t3_ovf_sticky", 32'(bus.Ovf), 32'd1);

    // positive overflow after an Ovf=1 command
    mem1[0] = 8'h7F; mem1[1] = 8'h01;
    start_cmd(4'd0, 4'd12, 4'd1);
    finish_cmd(1);
    chk("t4a_m2_12", 32'(mem2[12]), 32'h80);
    chk("t4a_ovf",   32'(bus.Ovf),  32'd1);

    // reset during RD2 of a running command
    mem1[0] = 8'h11; mem1[1] = 8'h22;
    w0 = wr_cnt;
    start_cmd(4'd0, 4'd7, 4'd3);
    @(posedge Clock); #1;
    model_reset(cyc);
    ResetN = 1'b0;
    #1;
    chk("t1_busy",   32'(bus.Busy),   32'd0);
    chk("t1_m1rd",   32'(bus.M1Rd),   32'd0);
    chk("t1_m1addr", 32'(bus.M1Addr), 32'd0);
    chk("t1_m2we",   32'(bus.M2WE),   32'd0);
    chk("t1_m2addr", 32'(bus.M2Addr), 32'd0);
    chk("t1_m2din",  32'(bus.M2DIn),  32'd0);
    chk("t1_dout1",  32'(bus.DOut1),  32'd0);
    chk("t1_dout2",  32'(bus.DOut2),  32'd0);
    chk("t1_done",   32'(bus.Done),   32'd0);
    chk("t1_ovf",    32'(bus.Ovf),    32'd0);
    repeat (2) @(posedge Clock);
    #3 ResetN = 1'b1;
    repeat (14) @(posedge Clock); #1;
    chk("t1_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t1_idle", 32'(bus.Busy), 32'd0);

    // non-overflowing pair clears Ovf
    mem1[2] = 8'h00; mem1[3] = 8'hFF;
    start_cmd(4'd2, 4'd13, 4'd1);
    finish_cmd(1);
    chk("t4b_m2_13", 32'(mem2[13]), 32'hFF);
    chk("t4b_ovf",   32'(bus.Ovf),  32'd0);

    // Length=0 with Start held three cycles: DONE-cycle Start ignored,
    // following IDLE cycle accepts a second command
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge Clock);
    bus.SrcBase = 4'd0; bus.DstBase = 4'd0; bus.Length = 4'd0; bus.Start = 1'b1;
    s = cyc;
    plan(s, 4'd0, 4'd0, 4'd0);
    plan(s + 2, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge Clock);
    #1 bus.Start = 1'b0;
    repeat (3) @(posedge Clock); #1;
    chk("t5_len0_dones", 32'(done_cnt - d0), 32'd2);
    chk("t5_len0_last_done", 32'(last_done - s), 32'd3);
    chk("t5_len0_writes", 32'(wr_cnt - w0), 32'd0);

    // Start pulses while busy are ignored
    mem1[4] = 8'h01; mem1[5] = 8'h02; mem1[6] = 8'h03;
    mem1[7] = 8'h04; mem1[8] = 8'h05; mem1[9] = 8'h06;
    w0 = wr_cnt;
    start_cmd(4'd4, 4'd1, 4'd3);
    @(negedge Clock);
    bus.Start = 1'b1; bus.SrcBase = 4'd0; bus.DstBase = 4'd14; bus.Length = 4'd0;
    @(posedge Clock); #1 bus.Start = 1'b0;
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Length = 4'd5;
    @(posedge Clock); #1 bus.Start = 1'b0;
    repeat (6) @(posedge Clock); #1;
    chk("t5_writes", 32'(wr_cnt - w0), 32'd3);
    chk("t5_m2_1", 32'(mem2[1]), 32'h03);
    chk("t5_m2_2", 32'(mem2[2]), 32'h07);
    chk("t5_m2_3", 32'(mem2[3]), 32'h0B);

    // address wrap on both pointers
    mem1[15] = 8'h10; mem1[0] = 8'h20; mem1[1] = 8'h30; mem1[2] = 8'h40;
    start_cmd(4'd15, 4'd15, 4'd2);
    finish_cmd(2);
    chk("t6_m2_15", 32'(mem2[15]), 32'h30);
    chk("t6_m2_0",  32'(mem2[0]),  32'h70);
    repeat (2) @(posedge Clock); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
